uart_rx_buffer_ctrl: RTL

//   Buffers bytes from the UART receiver in a FIFO and exposes them to the CPU
//   as a two-word memory-mapped peripheral: DATA at addr 0, STATUS/CONTROL at addr 1.

---
 rtl/uart_rx_buffer_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/uart_rx_buffer_ctrl.sv
// UART receive FIFO exposed as a two-word CPU peripheral (DATA at 0, STATUS/CONTROL at 1).
// Optional idle timeout flag is enabled with `define UART_RX_TIMEOUT_EN.
module uart_rx_buffer_ctrl #(
    parameter int DEPTH_LOG2   = 4,
    parameter int IRQ_LEVEL    = 8,
    parameter int TIMEOUT_CLKS = 52083
) (
    input  logic        clk50Mhz,
    input  logic        reset,
    input  logic        rxValid,
    input  logic [7:0]  rxData,
    input  logic        cpuRd,
    input  logic        cpuWr,
    input  logic        cpuAddr,
    input  logic [15:0] cpuWData,
    output logic [15:0] cpuRData,
    output logic        irq
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] IRQ_CNT  = (DEPTH_LOG2 + 1)'(IRQ_LEVEL);

    logic [7:0]          mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
    logic [DEPTH_LOG2:0] count, count_next;
    logic                overflow, overflow_next;
    logic                timeout, timeout_next;
    logic                empty, full;
    logic                pop_req, pop, push, flush, clr_ovf, ovf_evt;
    logic                stat_rd, ctrl_wr;
    logic [7:0]          rd_byte;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign rd_byte = mem[rd_ptr[DEPTH_LOG2-1:0]];

    assign pop_req = cpuRd && !cpuAddr;
    assign pop     = pop_req && !empty;
    assign stat_rd = cpuRd && cpuAddr;
    assign ctrl_wr = cpuWr && cpuAddr;
    assign flush   = ctrl_wr && cpuWData[1];
    assign clr_ovf = ctrl_wr && cpuWData[0];

    // A flush discards any byte arriving in the same cycle, so it neither
    // pushes nor counts as an overflow.
    assign push    = rxValid && !flush && (!full || pop);
    assign ovf_evt = rxValid && !flush && full && !pop;

    assign wr_ptr_next   = wr_ptr + {{DEPTH_LOG2{1'b0}}, push};
    assign rd_ptr_next   = flush ? wr_ptr : rd_ptr + {{DEPTH_LOG2{1'b0}}, pop};
    assign count_next    = wr_ptr_next - rd_ptr_next;
    assign overflow_next = ovf_evt || (overflow && !clr_ovf);

`ifdef UART_RX_TIMEOUT_EN
    localparam logic [16:0] TO_CNT = 17'(TIMEOUT_CLKS);

    logic [16:0] idle_cnt, idle_next;
    logic        clr_to, to_evt;

    assign clr_to = ctrl_wr && cpuWData[2];

    always_comb begin
        idle_next = idle_cnt;
        to_evt    = 1'b0;
        if (push || flush) begin
            idle_next = '0;
        end else if (!empty && idle_cnt < TO_CNT) begin
            idle_next = idle_cnt + 17'd1;
            // Only the step onto the limit sets the flag, so clearing it while
            // the counter sits saturated does not immediately re-set it.
            to_evt    = (idle_next == TO_CNT);
        end
    end

    assign timeout_next = to_evt || (timeout && !clr_to && !flush);

    always_ff @(posedge clk50Mhz) begin
        if (!reset) begin
            idle_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            idle_cnt <= idle_next;
            timeout  <= timeout_next;
        end
    end
`else
    assign timeout      = 1'b0;
    assign timeout_next = 1'b0;
`endif

    always_ff @(posedge clk50Mhz) begin
        if (push) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= rxData;
        end
    end

    always_ff @(posedge clk50Mhz) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            irq      <= 1'b0;
            cpuRData <= 16'h0000;
        end else begin
            wr_ptr   <= wr_ptr_next;
            rd_ptr   <= rd_ptr_next;
            overflow <= overflow_next;
            irq      <= (count_next >= IRQ_CNT) || overflow_next || timeout_next;
            if (pop_req) begin
                cpuRData <= pop ? {7'b0, 1'b1, rd_byte} : 16'h0000;
            end else if (stat_rd) begin
                cpuRData <= {irq, overflow, timeout, 5'b0, 8'(count)};
            end
        end
    end
endmodule
